// File: rtl/rtclock_mc.sv
// rtclock_mc: 48-bit seconds / 30-bit nanoseconds real-time clock with pps, per-channel timestamp capture
// and an AXI4-Lite register slave. Define RTCLOCK_MC_TRIM_EN to make the per-cycle increment (INC) writable.
module rtclock_mc #(
    parameter int unsigned                   C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned                   C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = '0,
    parameter int unsigned                   C_CLK_TO_NS_RATIO  = 8,
    parameter int unsigned                   C_NUM_CAP          = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [C_NUM_CAP-1:0]              cap_in,
    output logic [47:0]                       sec,
    output logic [29:0]                       nsec,
    output logic                              pps,
    output logic                              cap_irq,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned OFF_FLIP = 0;
    localparam int unsigned OFF_CTRL = 4;
    localparam int unsigned OFF_SSLO = 8;
    localparam int unsigned OFF_SSHI = 12;
    localparam int unsigned OFF_SNS  = 16;
    localparam int unsigned OFF_STAT = 20;
    localparam int unsigned OFF_INC  = 24;
    localparam int unsigned OFF_NOW  = 28;
    localparam int unsigned OFF_CAP  = 64;
    localparam logic [30:0] NS_PER_SEC = 31'd1_000_000_000;
    localparam logic [29:0] NS_MAX     = 30'd999_999_999;

    logic           aw_ready, wr_hs, rd_hs, wr_ok, rd_ok, wr_stat;
    logic [AW-1:0]  wr_off, rd_off;
    logic [31:0]    wmask, wd_m, rd_data;
    logic [31:0]    flip, set_sec_lo;
    logic [15:0]    set_sec_hi;
    logic [29:0]    set_nsec, set_nsec_cl;
    logic [47:0]    set_sec;
    logic           en, load_pend, roll;
    logic [7:0]     inc;
    logic [30:0]    nsum;
    logic [C_NUM_CAP-1:0] s1, s2, s3, cap_edge, valid, ovf, valid_n, ovf_n, clr_v, clr_o;
    logic [47:0]    cap_sec  [C_NUM_CAP];
    logic [29:0]    cap_nsec [C_NUM_CAP];

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = aw_ready;
    assign wr_hs   = aw_ready & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_hs   = S_AXI_ARREADY & S_AXI_ARVALID;
    assign wr_off  = (S_AXI_AWADDR - C_BASEADDR) & ~AW'(3);
    assign rd_off  = (S_AXI_ARADDR - C_BASEADDR) & ~AW'(3);
    assign wmask   = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
    assign wd_m    = S_AXI_WDATA & wmask;
    assign wr_stat = wr_hs && (wr_off == AW'(OFF_STAT));

    assign set_sec     = {set_sec_hi, set_sec_lo};
    assign set_nsec_cl = (set_nsec > NS_MAX) ? NS_MAX : set_nsec;
    assign nsum        = {1'b0, nsec} + {23'b0, inc};
    assign roll        = (nsum >= NS_PER_SEC);

    // Time counter; a pending load beats increment and rollover
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sec  <= '0;
            nsec <= '0;
            pps  <= 1'b0;
        end else if (load_pend) begin
            sec  <= set_sec;
            nsec <= set_nsec_cl;
            pps  <= (set_sec != sec);
        end else if (en && roll) begin
            sec  <= sec + 48'd1;
            nsec <= 30'(nsum - NS_PER_SEC);
            pps  <= 1'b1;
        end else begin
            if (en) nsec <= nsum[29:0];
            pps <= 1'b0;
        end
    end

`ifdef RTCLOCK_MC_TRIM_EN
    // Runtime increment trim; a zero write is ignored
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            inc <= 8'(C_CLK_TO_NS_RATIO);
        else if (wr_hs && (wr_off == AW'(OFF_INC)) && (wd_m[7:0] != 8'd0))
            inc <= wd_m[7:0];
    end
`else
    assign inc = 8'(C_CLK_TO_NS_RATIO);
`endif

    // Writable control and set-time registers, byte strobes honoured
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flip       <= '0;
            en         <= 1'b0;
            load_pend  <= 1'b0;
            set_sec_lo <= '0;
            set_sec_hi <= '0;
            set_nsec   <= '0;
        end else begin
            load_pend <= 1'b0;
            if (wr_hs) begin
                case (wr_off)
                    AW'(OFF_FLIP): flip <= (flip & ~wmask) | wd_m;
                    AW'(OFF_CTRL): begin
                        en        <= (en & ~wmask[0]) | wd_m[0];
                        load_pend <= wd_m[1];
                    end
                    AW'(OFF_SSLO): set_sec_lo <= (set_sec_lo & ~wmask) | wd_m;
                    AW'(OFF_SSHI): set_sec_hi <= (set_sec_hi & ~wmask[15:0]) | wd_m[15:0];
                    AW'(OFF_SNS):  set_nsec   <= (set_nsec & ~wmask[29:0]) | wd_m[29:0];
                    default: ;
                endcase
            end
        end
    end

    // Capture: a new edge sets valid (and overrides a same-cycle clear); a repeat edge only flags overflow
    assign clr_v    = wr_stat ? wd_m[C_NUM_CAP-1:0] : '0;
    assign clr_o    = wr_stat ? wd_m[16 +: C_NUM_CAP] : '0;
    assign cap_edge = s2 & ~s3;
    assign valid_n  = (valid & ~clr_v) | cap_edge;
    assign ovf_n    = (ovf & ~clr_o) | (cap_edge & valid);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            valid   <= '0;
            ovf     <= '0;
            cap_irq <= 1'b0;
            for (int unsigned i = 0; i < C_NUM_CAP; i++) begin
                cap_sec[i]  <= '0;
                cap_nsec[i] <= '0;
            end
        end else begin
            s1      <= cap_in;
            s2      <= s1;
            s3      <= s2;
            valid   <= valid_n;
            ovf     <= ovf_n;
            cap_irq <= |valid_n;
            for (int unsigned i = 0; i < C_NUM_CAP; i++) begin
                if (cap_edge[i] && !valid[i]) begin
                    cap_sec[i]  <= sec;
                    cap_nsec[i] <= nsec;
                end
            end
        end
    end

    // Write address decode for the response code
    always_comb begin
        wr_ok = (wr_off < AW'(32));
        for (int unsigned i = 0; i < C_NUM_CAP; i++) begin
            if ((wr_off == AW'(OFF_CAP + 16*i)) || (wr_off == AW'(OFF_CAP + 16*i + 4)) ||
                (wr_off == AW'(OFF_CAP + 16*i + 8)))
                wr_ok = 1'b1;
        end
    end

    // Read mux
    always_comb begin
        rd_data = '0;
        rd_ok   = 1'b1;
        case (rd_off)
            AW'(OFF_FLIP): rd_data = ~flip;
            AW'(OFF_CTRL): rd_data = {31'b0, en};
            AW'(OFF_SSLO): rd_data = set_sec_lo;
            AW'(OFF_SSHI): rd_data = {16'b0, set_sec_hi};
            AW'(OFF_SNS):  rd_data = {2'b0, set_nsec};
            AW'(OFF_STAT): begin
                rd_data[C_NUM_CAP-1:0]   = valid;
                rd_data[16 +: C_NUM_CAP] = ovf;
            end
            AW'(OFF_INC):  rd_data = {24'b0, inc};
            AW'(OFF_NOW):  rd_data = {2'b0, nsec};
            default: begin
                rd_ok = 1'b0;
                for (int unsigned i = 0; i < C_NUM_CAP; i++) begin
                    if (rd_off == AW'(OFF_CAP + 16*i)) begin
                        rd_data = cap_sec[i][31:0];
                        rd_ok   = 1'b1;
                    end
                    if (rd_off == AW'(OFF_CAP + 16*i + 4)) begin
                        rd_data = {16'b0, cap_sec[i][47:32]};
                        rd_ok   = 1'b1;
                    end
                    if (rd_off == AW'(OFF_CAP + 16*i + 8)) begin
                        rd_data = {2'b0, cap_nsec[i]};
                        rd_ok   = 1'b1;
                    end
                end
            end
        endcase
    end

    // AXI4-Lite handshakes: one outstanding write and one outstanding read
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_ready      <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RDATA   <= '0;
        end else begin
            aw_ready <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !aw_ready;
            if (wr_hs) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_ok ? 2'b00 : 2'b10;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
            S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
            if (rd_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_data;
                S_AXI_RRESP  <= rd_ok ? 2'b00 : 2'b10;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rtclock_mc.sv
// Directed self-checking bench for rtclock_mc: AXI register access, load/rollover/pps, capture and error responses.
module tb_rtclock_mc;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [3:0]  cap_in = '0;
    logic [47:0] sec;
    logic [29:0] nsec;
    logic        pps, cap_irq;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int last_hs;

    rtclock_mc dut (
        .clk(clk), .resetn(resetn), .cap_in(cap_in),
        .sec(sec), .nsec(nsec), .pps(pps), .cap_irq(cap_irq),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one tick after the handshake edge; hs_cyc is that edge's cycle number
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output int hs_cyc);
        logic got = 1'b0;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            got = awready & wready;
        end
        chk("awready_wait", 64'(got), 64'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid", 64'(bvalid), 64'd1);
        resp = bresp;
        hs_cyc = cyc;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int hs_cyc);
        logic got = 1'b0;
        araddr = addr; arvalid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            got = arready;
        end
        chk("arready_wait", 64'(got), 64'd1);
        step();
        arvalid = 1'b0;
        chk("rvalid", 64'(rvalid), 64'd1);
        data = rdata;
        resp = rresp;
        hs_cyc = cyc;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] r;
        int c;
        axi_write(addr, data, strb, r, c);
        last_hs = c;
        chk(tag, 64'(r), 64'(exp_resp));
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                      input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        int c;
        axi_read(addr, d, r, c);
        chk(tag, 64'(d), 64'(exp_data));
        chk({tag, "_resp"}, 64'(r), 64'(exp_resp));
    endtask

    initial begin
        int t3, m, c;
        logic [31:0] d;
        logic [1:0]  r;
        logic [29:0] n1;
        logic [31:0] exp_ts;

        #2 resetn = 1'b0;
        repeat (3) step();
        chk("rst_sec", 64'(sec), 64'd0);
        chk("rst_nsec", 64'(nsec), 64'd0);
        chk("rst_pps", 64'(pps), 64'd0);
        chk("rst_irq", 64'(cap_irq), 64'd0);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        resetn = 1'b1;
        step();

        // FLIP register
        rd("flip_reset", 32'h00, 32'hFFFF_FFFF, 2'b00);
        wr("flip_wr", 32'h00, 32'h1234_5678, 4'hF, 2'b00);
        rd("flip_rd", 32'h00, 32'hEDCB_A987, 2'b00);
        wr("flip_wr_b0", 32'h00, 32'hAABB_CCDD, 4'b0001, 2'b00);
        rd("flip_strb", 32'h00, 32'hEDCB_A922, 2'b00);

        // Load then rollover after three increments of 8
        wr("ssec_lo", 32'h08, 32'd5, 4'hF, 2'b00);
        wr("ssec_hi", 32'h0C, 32'd0, 4'hF, 2'b00);
        wr("snsec", 32'h10, 32'd999_999_976, 4'hF, 2'b00);
        wr("ctrl_en_load", 32'h04, 32'h3, 4'hF, 2'b00);
        step();
        chk("load_sec", 64'(sec), 64'd5);
        chk("load_nsec", 64'(nsec), 64'd999_999_976);
        chk("load_pps", 64'(pps), 64'd1);
        step();
        chk("inc1_nsec", 64'(nsec), 64'd999_999_984);
        chk("inc1_pps", 64'(pps), 64'd0);
        step();
        chk("inc2_nsec", 64'(nsec), 64'd999_999_992);
        step();
        chk("roll_sec", 64'(sec), 64'd6);
        chk("roll_nsec", 64'(nsec), 64'd0);
        chk("roll_pps", 64'(pps), 64'd1);
        step();
        chk("post_nsec", 64'(nsec), 64'd8);
        chk("post_pps", 64'(pps), 64'd0);

        // Clamped load with the counter stopped
        wr("ssec_lo7", 32'h08, 32'd7, 4'hF, 2'b00);
        wr("snsec_big", 32'h10, 32'h3FFF_FFFF, 4'hF, 2'b00);
        wr("ctrl_load", 32'h04, 32'h2, 4'hF, 2'b00);
        step();
        chk("clamp_sec", 64'(sec), 64'd7);
        chk("clamp_nsec", 64'(nsec), 64'd999_999_999);
        repeat (3) step();
        chk("frozen_nsec", 64'(nsec), 64'd999_999_999);
        rd("ctrl_rd", 32'h04, 32'h0, 2'b00);

        // Capture on channel 2 with counter running from a known time
        wr("ssec_lo3", 32'h08, 32'h1234, 4'hF, 2'b00);
        wr("snsec3", 32'h10, 32'd1000, 4'hF, 2'b00);
        wr("ctrl3", 32'h04, 32'h3, 4'hF, 2'b00);
        t3 = last_hs;
        repeat (4) step();
        m = cyc;
        chk("live_nsec", 64'(nsec), 64'(1000 + 8 * (m - t3 - 1)));
        exp_ts = 32'(1000 + 8 * (m + 1 - t3));
        cap_in[2] = 1'b1;
        repeat (2) step();
        cap_in[2] = 1'b0;
        repeat (4) step();
        chk("cap2_irq", 64'(cap_irq), 64'd1);
        rd("cap2_status", 32'h14, 32'h0000_0004, 2'b00);
        rd("cap2_seclo", 32'h60, 32'h1234, 2'b00);
        rd("cap2_sechi", 32'h64, 32'h0, 2'b00);
        rd("cap2_nsec", 32'h68, exp_ts, 2'b00);
        wr("w1c2", 32'h14, 32'h4, 4'hF, 2'b00);
        chk("w1c2_irq", 64'(cap_irq), 64'd0);
        rd("w1c2_status", 32'h14, 32'h0, 2'b00);
        axi_read(32'h1C, d, r, c);
        chk("now_nsec", 64'(d), 64'(1000 + 8 * (c - 1 - t3 - 1)));

        // Two edges on channel 0: first timestamp kept, overflow flagged
        m = cyc;
        exp_ts = 32'(1000 + 8 * (m + 1 - t3));
        cap_in[0] = 1'b1;
        repeat (2) step();
        cap_in[0] = 1'b0;
        repeat (3) step();
        cap_in[0] = 1'b1;
        repeat (2) step();
        cap_in[0] = 1'b0;
        repeat (4) step();
        chk("cap0_irq", 64'(cap_irq), 64'd1);
        rd("cap0_status", 32'h14, 32'h0001_0001, 2'b00);
        rd("cap0_nsec", 32'h48, exp_ts, 2'b00);
        rd("cap0_seclo", 32'h40, 32'h1234, 2'b00);
        wr("w1c0", 32'h14, 32'h0001_0001, 4'hF, 2'b00);
        rd("w1c0_status", 32'h14, 32'h0, 2'b00);

        // Unmapped addresses and write-response backpressure
        rd("unmap_3c", 32'h3C, 32'h0, 2'b10);
        rd("unmap_4c", 32'h4C, 32'h0, 2'b10);
        rd("unmap_80", 32'h80, 32'h0, 2'b10);
        bready = 1'b0;
        wr("unmap_wr", 32'h3C, 32'hDEAD_BEEF, 4'hF, 2'b10);
        awaddr = 32'h3C; awvalid = 1'b1; wvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_bvalid", 64'(bvalid), 64'd1);
            chk("bp_awready", 64'(awready), 64'd0);
        end
        bready = 1'b1;
        step();
        chk("bp_release", 64'(bvalid), 64'd0);
        begin
            logic got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                step();
                got = awready;
            end
            chk("bp_second_aw", 64'(got), 64'd1);
        end
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_second_bresp", 64'(bresp), 64'd2);
        step();
        rd("flip_kept", 32'h00, 32'hEDCB_A922, 2'b00);

        // Increment register
`ifdef RTCLOCK_MC_TRIM_EN
        wr("inc10", 32'h18, 32'd10, 4'hF, 2'b00);
        step();
        n1 = nsec;
        step();
        chk("inc10_step", 64'(nsec - n1), 64'd10);
        wr("inc0", 32'h18, 32'd0, 4'hF, 2'b00);
        rd("inc_kept", 32'h18, 32'd10, 2'b00);
        n1 = nsec;
        step();
        chk("inc0_step", 64'(nsec - n1), 64'd10);
`else
        rd("inc_fixed", 32'h18, 32'd8, 2'b00);
        wr("inc_wr", 32'h18, 32'd55, 4'hF, 2'b00);
        rd("inc_fixed2", 32'h18, 32'd8, 2'b00);
        n1 = nsec;
        step();
        chk("inc_step", 64'(nsec - n1), 64'd8);
`endif

        // Reset in the middle of a read
        rready = 1'b0;
        araddr = 32'h00; arvalid = 1'b1;
        repeat (3) step();
        resetn = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_arready", 64'(arready), 64'd0);
        chk("mid_rst_sec", 64'(sec), 64'd0);
        arvalid = 1'b0;
        rready = 1'b1;
        step();
        resetn = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
